// File: rtl/param_shift_register_if.sv
// Bus bundle for param_shift_register: control, serial/parallel data in and
// register state, serial outs, shift count and frame-complete pulse out.
interface param_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    count;
  logic             done;

  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  q, sout_r, sout_l, count, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output q, sout_r, sout_l, count, done
  );
endinterface

// File: rtl/param_shift_register.sv
// Universal shift register with shift counter and one-cycle frame-complete pulse.
// Define SHIFT_REG_SRA_EN to make mode 3'b111 an arithmetic shift right (else hold).
module param_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                    clk,
  input logic                    rst,
  param_shift_register_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic             r_done;

  logic [WIDTH-1:0] w_next_q;
  logic             w_is_shift;
  logic             w_zero_cnt;

  always_comb begin
    w_next_q   = r_q;
    w_is_shift = 1'b0;
    w_zero_cnt = 1'b0;
    case (bus.mode)
      3'b001: begin
        w_next_q   = {bus.sin_r, r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      3'b010: begin
        w_next_q   = {r_q[WIDTH-2:0], bus.sin_l};
        w_is_shift = 1'b1;
      end
      3'b011: begin
        w_next_q   = {r_q[0], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      3'b100: begin
        w_next_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_is_shift = 1'b1;
      end
      3'b101: begin
        w_next_q   = bus.pin;
        w_zero_cnt = 1'b1;
      end
      3'b110: begin
        w_next_q   = '0;
        w_zero_cnt = 1'b1;
      end
`ifdef SHIFT_REG_SRA_EN
      3'b111: begin
        w_next_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // done is a strict one-cycle pulse, so it clears on every edge even with en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= RESET_VAL;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.en) begin
        r_q <= w_next_q;
        if (w_zero_cnt) begin
          r_count <= '0;
        end else if (w_is_shift && (r_count != CNT_FULL)) begin
          r_count <= r_count + 1'b1;
          r_done  <= (r_count == CNT_LAST);
        end
      end
    end
  end

  assign bus.q      = r_q;
  assign bus.sout_r = r_q[0];
  assign bus.sout_l = r_q[WIDTH-1];
  assign bus.count  = r_count;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_param_shift_register.sv
// Self-checking bench for param_shift_register (WIDTH=8): directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_param_shift_register;
  localparam int W = 8;

  logic clk;
  logic rst;
  param_shift_register_if #(.WIDTH(W)) bus ();

  param_shift_register #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_q;
  int m_cnt;
  int m_done;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_done = 0;
  endtask

  // One clock edge of the reference behaviour, using the currently driven inputs.
  task automatic model_edge();
    int sh;
    if (!rst) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!bus.en) return;
    sh = 0;
    case (int'(bus.mode))
      1: begin m_q = (m_q >> 1) | (int'(bus.sin_r) * 128); sh = 1; end
      2: begin m_q = ((m_q * 2) % 256) + int'(bus.sin_l); sh = 1; end
      3: begin m_q = (m_q >> 1) | ((m_q % 2) * 128); sh = 1; end
      4: begin m_q = ((m_q * 2) % 256) + (m_q / 128); sh = 1; end
      5: begin m_q = int'(bus.pin); m_cnt = 0; end
      6: begin m_q = 0; m_cnt = 0; end
`ifdef SHIFT_REG_SRA_EN
      7: begin m_q = (m_q >> 1) | (m_q & 128); sh = 1; end
`endif
      default: ;
    endcase
    if (sh == 1 && m_cnt < W) begin
      m_cnt++;
      if (m_cnt == W) m_done = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},      64'(bus.q),      64'(m_q));
    check({tag, ".count"},  64'(bus.count),  64'(m_cnt));
    check({tag, ".done"},   64'(bus.done),   64'(m_done));
    check({tag, ".sout_r"}, 64'(bus.sout_r), 64'(m_q % 2));
    check({tag, ".sout_l"}, 64'(bus.sout_l), 64'(m_q / 128));
  endtask

  // driver: apply inputs, take one edge, sample 1 time unit later
  task automatic drive(input logic en, input logic [2:0] mode, input logic sr,
                       input logic sl, input logic [W-1:0] pin);
    bus.en = en; bus.mode = mode; bus.sin_r = sr; bus.sin_l = sl; bus.pin = pin;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int done_seen;
  logic [7:0] stream;
  logic [W-1:0] exp_bit;

  initial begin
    rst = 1'b0;
    bus.en = 1'b1; bus.mode = 3'b101; bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.pin = 8'hFF;
    model_reset();

    // reset held while clocking a load
    repeat (3) drive(1'b1, 3'b101, 1'b0, 1'b0, 8'hFF);
    check("rst.q", 64'(bus.q), 64'h00);
    check("rst.count", 64'(bus.count), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 3'b101, 1'b0, 1'b0, 8'hFF);
    check("rst_rel.q", 64'(bus.q), 64'h00);
    check_all("rst_rel");

    // load then 8 rotates right
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'hA5);
    check_all("rot.load");
    done_seen = 0;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
      check_all("rot.step");
      if (bus.done) done_seen++;
    end
    check("rot.q", 64'(bus.q), 64'hA5);
    check("rot.count", 64'(bus.count), 64'd8);
    check("rot.done_last", 64'(bus.done), 64'd1);
    drive(1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
    if (bus.done) done_seen++;
    check("rot.done_pulses", 64'(done_seen), 64'd1);
    check_all("rot.sat");

    // serial in right shift, then serialize it back out
    drive(1'b1, 3'b110, 1'b0, 1'b0, 8'h00);
    check_all("ser.clr");
    stream = 8'b0100_1101;  // bit i enters on cycle i: 1,0,1,1,0,0,1,0
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(W'(stream[i]));
      drive(1'b1, 3'b001, stream[i], 1'b0, 8'h00);
      check_all("ser.in");
      if (bus.done) done_seen++;
    end
    check("ser.q", 64'(bus.q), 64'h4D);
    check("ser.done_pulses", 64'(done_seen), 64'd1);
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'h4D);
    for (int i = 0; i < 8; i++) begin
      exp_bit = exp_q.pop_front();
      check("ser.sout_r", 64'(bus.sout_r), 64'(exp_bit[0]));
      drive(1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
    end

    // left shift with enable gating
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'h81);
    drive(1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
    check("lsh.q1", 64'(bus.q), 64'h03);
    drive(1'b0, 3'b010, 1'b0, 1'b1, 8'h00);
    check("lsh.hold", 64'(bus.q), 64'h03);
    drive(1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 3'b010, 1'b0, 1'b1, 8'h00);
    check("lsh.q", 64'(bus.q), 64'h07);
    check("lsh.count", 64'(bus.count), 64'd2);
    check_all("lsh");

    // load wins over the would-be final shift
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'h11);
    repeat (W - 1) drive(1'b1, 3'b100, 1'b0, 1'b0, 8'h00);
    check("ldwin.count7", 64'(bus.count), 64'd7);
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'h3C);
    check("ldwin.q", 64'(bus.q), 64'h3C);
    check("ldwin.count", 64'(bus.count), 64'd0);
    check("ldwin.done", 64'(bus.done), 64'd0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
    check("ldwin.done_after", 64'(bus.done), 64'd0);

    // asynchronous reset mid-frame
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'h5A);
    repeat (5) drive(1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    check("arst.count5", 64'(bus.count), 64'd5);
    #2 rst = 1'b0;
    #1;
    check("arst.q", 64'(bus.q), 64'h00);
    check("arst.count", 64'(bus.count), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // mode 111
    drive(1'b1, 3'b101, 1'b0, 1'b0, 8'h90);
    drive(1'b1, 3'b111, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 3'b111, 1'b1, 1'b0, 8'h00);
`ifdef SHIFT_REG_SRA_EN
    check("sra.q", 64'(bus.q), 64'hE4);
    check("sra.count", 64'(bus.count), 64'd2);
`else
    check("sra.q", 64'(bus.q), 64'h90);
    check("sra.count", 64'(bus.count), 64'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
